queue_level_encoder: RTL and testbench

//  Upstream stage of the reward decider; produces per-road L codes L0..L3 on agent request.

---
 rtl/intellight_pkg.sv | 33 +++
 rtl/queue_counter.sv | 69 ++++++
 rtl/queue_level_encoder.sv | 180 ++++++++++++++++++
 tb/tb_queue_level_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/intellight_pkg.sv
// -----------------------------------------------------------------------------
// intellight_pkg
//   Shared encodings for the queue level encoder feeding the reward decider:
//   - cls_e   : congestion class codes, upper half of an L code
//   - tr_e    : queue trend codes, lower half of an L code
//   - qle_state_e : encoder FSM state encoding
//   No ports (package).
// -----------------------------------------------------------------------------
package intellight_pkg;

    localparam int NUM_ROADS = 4;

    typedef enum logic [1:0] {
        CLS_FREE  = 2'd0,
        CLS_LIGHT = 2'd1,
        CLS_HEAVY = 2'd2,
        CLS_JAM   = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        TR_STABLE = 2'd0,
        TR_RISE   = 2'd1,
        TR_FALL   = 2'd2,
        TR_OVF    = 2'd3
    } tr_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } qle_state_e;

endpackage

// File: rtl/queue_counter.sv
// -----------------------------------------------------------------------------
// queue_counter
//   Per-road vehicle queue counter. Counts up on arrival, down on departure,
//   saturates at both ends, and keeps a sticky overflow flag that records any
//   arrival that was lost because the counter was already at its maximum.
// Ports
//   clk        in   clock, posedge
//   rst        in   synchronous active-high reset (count and flag to 0)
//   arr_i      in   arrival pulse
//   dep_i      in   departure pulse
//   ovf_clr_i  in   clear the overflow flag (a same-cycle overflow wins)
//   cnt_o      out  current queue length
//   ovf_o      out  sticky overflow flag
// -----------------------------------------------------------------------------
module queue_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 arr_i,
    input  logic                 dep_i,
    input  logic                 ovf_clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 ovf_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 arr_at_max;

    always_comb begin
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        arr_at_max = 1'b0;
        // Simultaneous arrival and departure cancel: count and flag untouched.
        if (arr_i && !dep_i) begin
            if (cnt_q == CNT_MAX) begin
                arr_at_max = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (dep_i && !arr_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_ONE;
        end
        // A lost arrival in the clearing cycle must not be forgotten.
        if (arr_at_max) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/queue_level_encoder.sv
// -----------------------------------------------------------------------------
// queue_level_encoder
//   Tracks the queue length of four roads and, on each agent step, snapshots
//   them and emits one L code per road = {class[3:2], trend[1:0]} through a
//   valid/ready handshake.
//   Optional feature macro: QLE_TREND_EN. When defined, L[1:0] carries the
//   trend versus the previous snapshot (overflow overrides). When undefined,
//   L[1:0] is 0 and the previous-snapshot storage is not built.
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   arr_i[3:0], dep_i[3:0]    per-road arrival / departure pulses
//   th_low, th_mid, th_high   class boundaries (unsigned)
//   sample_req                agent step strobe
//   l_ready                   consumer accepts the L codes
//   L0..L3                    per-road level codes
//   l_valid                   L0..L3 valid
//   sample_drop               pulse: a sample_req arrived while busy
// -----------------------------------------------------------------------------
module queue_level_encoder
    import intellight_pkg::*;
#(
    parameter int L_WIDTH   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           arr_i,
    input  logic [3:0]           dep_i,
    input  logic [CNT_WIDTH-1:0] th_low,
    input  logic [CNT_WIDTH-1:0] th_mid,
    input  logic [CNT_WIDTH-1:0] th_high,
    input  logic                 sample_req,
    input  logic                 l_ready,
    output logic [L_WIDTH-1:0]   L0,
    output logic [L_WIDTH-1:0]   L1,
    output logic [L_WIDTH-1:0]   L2,
    output logic [L_WIDTH-1:0]   L3,
    output logic                 l_valid,
    output logic                 sample_drop
);

    // The L code layout is fixed at {class, trend}.
    if (L_WIDTH != 4) begin : g_bad_lw
        $error("queue_level_encoder: L_WIDTH must be 4");
    end

    qle_state_e           state_q;
    logic [CNT_WIDTH-1:0] cnt    [NUM_ROADS];
    logic [NUM_ROADS-1:0] ovf;
    logic                 ovf_clr;
    logic [CNT_WIDTH-1:0] snap_q [NUM_ROADS];
    logic [L_WIDTH-1:0]   l_q    [NUM_ROADS];
    logic [L_WIDTH-1:0]   l_d    [NUM_ROADS];
    logic                 l_valid_q;
    logic                 sample_drop_q;
`ifdef QLE_TREND_EN
    logic [CNT_WIDTH-1:0] prev_q [NUM_ROADS];
    logic [NUM_ROADS-1:0] ovf_s_q;
`endif

    // Overflow flags are consumed by the snapshot taken on entry to CAPTURE,
    // so they are cleared while the codes are being registered.
    assign ovf_clr = (state_q == CAPTURE);

    for (genvar i = 0; i < NUM_ROADS; i++) begin : g_cnt
        queue_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .arr_i     (arr_i[i]),
            .dep_i     (dep_i[i]),
            .ovf_clr_i (ovf_clr),
            .cnt_o     (cnt[i]),
            .ovf_o     (ovf[i])
        );
    end

    // First-match classification; thresholds need not be monotonic.
    function automatic cls_e classify(input logic [CNT_WIDTH-1:0] v,
                                      input logic [CNT_WIDTH-1:0] lo,
                                      input logic [CNT_WIDTH-1:0] mid,
                                      input logic [CNT_WIDTH-1:0] hi);
        if (v < lo) begin
            return CLS_FREE;
        end else if (v < mid) begin
            return CLS_LIGHT;
        end else if (v < hi) begin
            return CLS_HEAVY;
        end
        return CLS_JAM;
    endfunction

`ifdef QLE_TREND_EN
    function automatic tr_e trend_of(input logic                 ovf_s,
                                     input logic [CNT_WIDTH-1:0] cur,
                                     input logic [CNT_WIDTH-1:0] prev);
        if (ovf_s) begin
            return TR_OVF;
        end else if (cur > prev) begin
            return TR_RISE;
        end else if (cur < prev) begin
            return TR_FALL;
        end
        return TR_STABLE;
    endfunction
`endif

    always_comb begin
        for (int i = 0; i < NUM_ROADS; i++) begin
`ifdef QLE_TREND_EN
            l_d[i] = {classify(snap_q[i], th_low, th_mid, th_high),
                      trend_of(ovf_s_q[i], snap_q[i], prev_q[i])};
`else
            l_d[i] = {classify(snap_q[i], th_low, th_mid, th_high), TR_STABLE};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            l_valid_q     <= 1'b0;
            sample_drop_q <= 1'b0;
            for (int i = 0; i < NUM_ROADS; i++) begin
                snap_q[i] <= '0;
                l_q[i]    <= '0;
`ifdef QLE_TREND_EN
                prev_q[i] <= '0;
`endif
            end
`ifdef QLE_TREND_EN
            ovf_s_q <= '0;
`endif
        end else begin
            sample_drop_q <= sample_req && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (sample_req) begin
                        // Snapshot is the pre-update count of this edge.
                        for (int i = 0; i < NUM_ROADS; i++) begin
                            snap_q[i] <= cnt[i];
                        end
`ifdef QLE_TREND_EN
                        ovf_s_q <= ovf;
`endif
                        state_q <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    for (int i = 0; i < NUM_ROADS; i++) begin
                        l_q[i] <= l_d[i];
`ifdef QLE_TREND_EN
                        prev_q[i] <= snap_q[i];
`endif
                    end
                    l_valid_q <= 1'b1;
                    state_q   <= HOLD;
                end
                HOLD: begin
                    if (l_ready) begin
                        l_valid_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign L0          = l_q[0];
    assign L1          = l_q[1];
    assign L2          = l_q[2];
    assign L3          = l_q[3];
    assign l_valid     = l_valid_q;
    assign sample_drop = sample_drop_q;

endmodule

// File: tb/tb_queue_level_encoder.sv
// -----------------------------------------------------------------------------
// tb_queue_level_encoder
//   Directed, table-driven bench for queue_level_encoder (CNT_WIDTH = 8).
//   Expected trend bits follow QLE_TREND_EN as seen by this compilation.
// -----------------------------------------------------------------------------
module tb_queue_level_encoder;

`ifdef QLE_TREND_EN
    localparam bit TREND = 1'b1;
`else
    localparam bit TREND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] arr_i, dep_i;
    logic [7:0] th_low, th_mid, th_high;
    logic       sample_req, l_ready;
    logic [3:0] L0, L1, L2, L3;
    logic       l_valid, sample_drop;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    queue_level_encoder #(
        .L_WIDTH   (4),
        .CNT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arr_i       (arr_i),
        .dep_i       (dep_i),
        .th_low      (th_low),
        .th_mid      (th_mid),
        .th_high     (th_high),
        .sample_req  (sample_req),
        .l_ready     (l_ready),
        .L0          (L0),
        .L1          (L1),
        .L2          (L2),
        .L3          (L3),
        .l_valid     (l_valid),
        .sample_drop (sample_drop)
    );

    typedef struct packed {
        logic [3:0][8:0] arr;
        logic [3:0][8:0] dep;
        logic [7:0]      lo;
        logic [7:0]      mid;
        logic [7:0]      hi;
        logic [3:0][1:0] cls;
        logic [3:0][1:0] tr;
    } vec_t;

    vec_t vecs [3];

    function automatic logic [3:0] code(input logic [1:0] c, input logic [1:0] t);
        return {c, (TREND ? t : 2'b00)};
    endfunction

    function automatic logic [3:0] get_l(input int i);
        case (i)
            0:       return L0;
            1:       return L1;
            2:       return L2;
            default: return L3;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_counts(input logic [3:0][8:0] n, input bit is_dep);
        int mx = 0;
        logic [3:0] m;
        for (int i = 0; i < 4; i++) if (int'(n[i]) > mx) mx = int'(n[i]);
        for (int k = 0; k < mx; k++) begin
            for (int i = 0; i < 4; i++) m[i] = (k < int'(n[i]));
            if (is_dep) dep_i = m; else arr_i = m;
            step();
        end
        arr_i = 4'h0;
        dep_i = 4'h0;
    endtask

    task automatic do_sample(input string tag);
        sample_req = 1'b1;
        step();
        sample_req = 1'b0;
        check({tag, " l_valid after E0"}, 32'(l_valid), 32'd0);
        step();
        check({tag, " l_valid after E1"}, 32'(l_valid), 32'd1);
    endtask

    task automatic accept(input string tag);
        l_ready = 1'b1;
        step();
        l_ready = 1'b0;
        check({tag, " l_valid after handshake"}, 32'(l_valid), 32'd0);
    endtask

    task automatic run_arr(input logic [3:0] a, input logic [3:0] d, input int n);
        arr_i = a;
        dep_i = d;
        repeat (n) step();
        arr_i = 4'h0;
        dep_i = 4'h0;
    endtask

    initial begin
        // Cumulative vectors: counts build on the previous vector's state.
        vecs[0] = '0;
        vecs[0].arr[0] = 9'd3;  vecs[0].arr[1] = 9'd7;
        vecs[0].arr[2] = 9'd15; vecs[0].arr[3] = 9'd25;
        vecs[0].lo = 8'd5; vecs[0].mid = 8'd10; vecs[0].hi = 8'd20;
        vecs[0].cls[0] = 2'd0; vecs[0].cls[1] = 2'd1; vecs[0].cls[2] = 2'd2; vecs[0].cls[3] = 2'd3;
        vecs[0].tr[0]  = 2'd1; vecs[0].tr[1]  = 2'd1; vecs[0].tr[2]  = 2'd1; vecs[0].tr[3]  = 2'd1;
        // counts 3,7,10,25: 10 sits exactly on th_mid
        vecs[1] = '0;
        vecs[1].dep[2] = 9'd5;
        vecs[1].lo = 8'd5; vecs[1].mid = 8'd10; vecs[1].hi = 8'd20;
        vecs[1].cls[0] = 2'd0; vecs[1].cls[1] = 2'd1; vecs[1].cls[2] = 2'd2; vecs[1].cls[3] = 2'd3;
        vecs[1].tr[0]  = 2'd0; vecs[1].tr[1]  = 2'd0; vecs[1].tr[2]  = 2'd2; vecs[1].tr[3]  = 2'd0;
        // road0 drained past empty -> 0; non-monotonic thresholds 8/4/30
        vecs[2] = '0;
        vecs[2].dep[0] = 9'd4;
        vecs[2].lo = 8'd8; vecs[2].mid = 8'd4; vecs[2].hi = 8'd30;
        vecs[2].cls[0] = 2'd0; vecs[2].cls[1] = 2'd0; vecs[2].cls[2] = 2'd2; vecs[2].cls[3] = 2'd2;
        vecs[2].tr[0]  = 2'd2; vecs[2].tr[1]  = 2'd0; vecs[2].tr[2]  = 2'd0; vecs[2].tr[3]  = 2'd0;

        rst = 1'b1; arr_i = 4'hF; dep_i = 4'h0;
        th_low = 8'd5; th_mid = 8'd10; th_high = 8'd20;
        sample_req = 1'b0; l_ready = 1'b0;
        step();
        rst = 1'b0;
        arr_i = 4'h0;
        check("reset l_valid", 32'(l_valid), 32'd0);
        check("reset sample_drop", 32'(sample_drop), 32'd0);
        check("reset L", 32'({L3, L2, L1, L0}), 32'd0);

        for (int v = 0; v < 3; v++) begin
            th_low = vecs[v].lo; th_mid = vecs[v].mid; th_high = vecs[v].hi;
            drive_counts(vecs[v].arr, 1'b0);
            drive_counts(vecs[v].dep, 1'b1);
            do_sample($sformatf("vec%0d", v));
            for (int i = 0; i < 4; i++)
                check($sformatf("vec%0d L%0d", v, i), 32'(get_l(i)),
                      32'(code(vecs[v].cls[i], vecs[v].tr[i])));
            accept($sformatf("vec%0d", v));
        end

        // Simultaneous arr/dep on road0, underflow on road1 (thresholds 8/4/30).
        run_arr(4'h1, 4'h0, 3);              // cnt0 = 3
        run_arr(4'h1, 4'h3, 12);             // cnt0 stays 3, cnt1 7 -> 0
        do_sample("simul");
        check("simul L0", 32'(L0), 32'(code(2'd0, 2'd1)));
        check("simul L1", 32'(L1), 32'(code(2'd0, 2'd2)));
        accept("simul");
        run_arr(4'h0, 4'h2, 5);              // dep on empty road1
        run_arr(4'h1, 4'h1, 10);
        do_sample("underflow");
        check("underflow L0", 32'(L0), 32'(code(2'd0, 2'd0)));
        check("underflow L1", 32'(L1), 32'(code(2'd0, 2'd0)));
        accept("underflow");

        // Saturation on road2: 10 + 260 arrivals clamps at 255.
        th_low = 8'd5; th_mid = 8'd10; th_high = 8'd20;
        run_arr(4'h4, 4'h0, 260);
        do_sample("sat");
        check("sat L2", 32'(L2), 32'(code(2'd3, 2'd3)));
        check("sat L3", 32'(L3), 32'(code(2'd3, 2'd0)));
        accept("sat");
        do_sample("sat2");
        check("sat2 L2 ovf cleared", 32'(L2), 32'(code(2'd3, 2'd0)));

        // Busy with l_ready low: requests dropped, outputs stable, arrivals still counted.
        for (int k = 0; k < 5; k++) begin
            sample_req = (k % 2 == 0);
            arr_i = 4'h8;
            step();
            check($sformatf("hold%0d sample_drop", k), 32'(sample_drop), 32'((k % 2) == 0));
            check($sformatf("hold%0d l_valid", k), 32'(l_valid), 32'd1);
            check($sformatf("hold%0d L2", k), 32'(L2), 32'(code(2'd3, 2'd0)));
            check($sformatf("hold%0d L3", k), 32'(L3), 32'(code(2'd3, 2'd0)));
        end
        sample_req = 1'b0;
        arr_i = 4'h0;
        accept("hold");
        check("hold sample_drop idle", 32'(sample_drop), 32'd0);

        // Accepted right after handshake; road3 now 30 vs prev 25.
        do_sample("post");
        check("post L3", 32'(L3), 32'(code(2'd3, 2'd1)));

        // Reset while in HOLD.
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst l_valid", 32'(l_valid), 32'd0);
        check("midrst L", 32'({L3, L2, L1, L0}), 32'd0);
        run_arr(4'h1, 4'h0, 6);
        do_sample("fresh");
        check("fresh L0", 32'(L0), 32'(code(2'd1, 2'd1)));
        check("fresh L3", 32'(L3), 32'(code(2'd0, 2'd0)));
        accept("fresh");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
